// File: rtl/axi_mem_pkg.sv
// Shared types for the AXI memory slave: burst/response encodings and FSM states.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI beat-address generator (FIXED/INCR/WRAP) with illegal-burst detection.
module axi_burst_addr
    import axi_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned MAX_SIZE = 2
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              illegal_o
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] incr_addr;
    logic              wrap_len_ok;

    always_comb begin
        step        = ADDR_W'(1) << size_i;
        span        = (ADDR_W'(len_i) + ADDR_W'(1)) << size_i;
        mask        = span - ADDR_W'(1);
        incr_addr   = addr_i + step;
        wrap_len_ok = (len_i == LEN_W'(1)) || (len_i == LEN_W'(3)) ||
                      (len_i == LEN_W'(7)) || (len_i == LEN_W'(15));
        illegal_o   = (32'(size_i) > MAX_SIZE) || (burst_i == 2'b11) ||
                      ((burst_i == BURST_WRAP) && !wrap_len_ok);
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            // Upper bits stay in the aligned window, low bits roll over inside it.
            BURST_WRAP:  next_addr_o = (addr_i & ~mask) | (incr_addr & mask);
            default:     next_addr_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// Burst-capable AXI3/AXI4 memory slave; independent write and read FSMs over one word array.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter  int unsigned ID_W      = 4,
    parameter  int unsigned ADDR_W    = 32,
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned LEN_W     = 4,
    parameter  int unsigned MEM_WORDS = 1024,
    localparam int unsigned STRB_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [LEN_W-1:0]  awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [LEN_W-1:0]  arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);

    localparam int unsigned LOG2_STRB = $clog2(STRB_W);
    localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'(STRB_W);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 64'(a) < MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> LOG2_STRB);
    endfunction

    // ---------------- write path ----------------
    wr_state_e         w_state_q, w_state_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d, w_id_q, w_id_d;
    logic [1:0]        bresp_q, bresp_d, w_burst_q, w_burst_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d, w_next_addr;
    logic [LEN_W-1:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]        w_size_q, w_size_d;
    logic              w_dec_q, w_dec_d, w_slv_q, w_slv_d, w_illegal;
    logic              aw_fire, w_fire, b_fire, w_last_beat, mem_we;
    logic [IDX_W-1:0]  mem_widx;

    assign aw_fire     = awvalid && awready_q;
    assign w_fire      = wvalid && wready_q;
    assign b_fire      = bvalid_q && bready;
    assign w_last_beat = (w_cnt_q == w_len_q);

    axi_burst_addr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_SIZE(LOG2_STRB)) u_waddr (
        .addr_i(w_addr_q), .size_i(w_size_q), .len_i(w_len_q), .burst_i(w_burst_q),
        .next_addr_o(w_next_addr), .illegal_o(w_illegal)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_dec_q   <= 1'b0;
            w_slv_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_dec_q   <= w_dec_d;
            w_slv_q   <= w_slv_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_fire) w_state_d = W_DATA;
            W_DATA:  if (w_fire && w_last_beat) w_state_d = W_RESP;
            W_RESP:  if (b_fire) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_dec_d   = w_dec_q;
        w_slv_d   = w_slv_q;
        mem_we    = 1'b0;
        mem_widx  = word_idx(w_addr_q);
        if (aw_fire) begin
            w_id_d    = awid;
            w_addr_d  = awaddr;
            w_len_d   = awlen;
            w_size_d  = awsize;
            w_burst_d = awburst;
            w_cnt_d   = '0;
            w_dec_d   = 1'b0;
            w_slv_d   = 1'b0;
        end
        if (w_fire) begin
            mem_we   = in_range(w_addr_q) && !w_illegal;
            w_dec_d  = w_dec_q || !in_range(w_addr_q);
            // The beat count, not wlast, ends the burst; a wlast mismatch is only reported.
            w_slv_d  = w_slv_q || w_illegal || (wlast != w_last_beat) ||
                       ((LEN_W == 4) && (wid != w_id_q));
            w_addr_d = w_next_addr;
            w_cnt_d  = w_cnt_q + LEN_W'(1);
            if (w_last_beat) begin
                bid_d   = w_id_q;
                bresp_d = w_dec_d ? RESP_DECERR : (w_slv_d ? RESP_SLVERR : RESP_OKAY);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[mem_widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_e         r_state_q, r_state_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_word;
    logic [1:0]        rresp_q, rresp_d, rd_resp, r_burst_q, r_burst_d, r_cur_burst;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d, r_cur_addr, r_next_addr, rd_addr;
    logic [LEN_W-1:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d, r_cur_len;
    logic [2:0]        r_size_q, r_size_d, r_cur_size;
    logic              r_illegal, ar_fire, r_fire;

    assign ar_fire = arvalid && arready_q;
    assign r_fire  = rvalid_q && rready;

    // While idle the generator judges the incoming AR request so beat 0 can load on the handshake.
    assign r_cur_addr  = (r_state_q == R_IDLE) ? araddr  : r_addr_q;
    assign r_cur_size  = (r_state_q == R_IDLE) ? arsize  : r_size_q;
    assign r_cur_len   = (r_state_q == R_IDLE) ? arlen   : r_len_q;
    assign r_cur_burst = (r_state_q == R_IDLE) ? arburst : r_burst_q;

    axi_burst_addr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_SIZE(LOG2_STRB)) u_raddr (
        .addr_i(r_cur_addr), .size_i(r_cur_size), .len_i(r_cur_len), .burst_i(r_cur_burst),
        .next_addr_o(r_next_addr), .illegal_o(r_illegal)
    );

    assign rd_addr = ar_fire ? araddr : r_next_addr;
    assign rd_word = (in_range(rd_addr) && !r_illegal) ? mem[word_idx(rd_addr)] : '0;
    assign rd_resp = !in_range(rd_addr) ? RESP_DECERR : (r_illegal ? RESP_SLVERR : RESP_OKAY);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_fire) r_state_d = R_DATA;
            R_DATA:  if (r_fire && rlast_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        if (ar_fire) begin
            rid_d     = arid;
            r_addr_d  = araddr;
            r_len_d   = arlen;
            r_size_d  = arsize;
            r_burst_d = arburst;
            r_cnt_d   = '0;
            rlast_d   = (arlen == '0);
            rdata_d   = rd_word;
            rresp_d   = rd_resp;
        end else if (r_fire) begin
            if (rlast_q) begin
                rlast_d = 1'b0;
            end else begin
                r_addr_d = r_next_addr;
                r_cnt_d  = r_cnt_q + LEN_W'(1);
                rlast_d  = (r_cnt_d == r_len_q);
                rdata_d  = rd_word;
                rresp_d  = rd_resp;
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed-vector bench: stimulus pushes expected B/R responses, a negedge monitor pops and compares.
module tb_axi_mem_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  awid, wid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi_mem_slave #(
        .ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .MEM_WORDS(1024)
    ) dut (
        .clk(clk), .resetn(resetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          r_seen = 0;
    bexp_t       bq[$];
    rexp_t       rq[$];
    logic [31:0] wbuf[16];
    logic [31:0] rbuf[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctrl"}, {awready, wready, bvalid, arready, rvalid, rlast}, 64'd0);
        chk({tag, "_ids_resp"}, {bid, rid, bresp, rresp}, 64'd0);
        chk({tag, "_rdata"}, rdata, 64'd0);
    endtask

    initial begin : monitor
        logic  stall;
        logic [34:0] held;
        bexp_t be;
        rexp_t re;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (resetn && stall) chk("r_stall_hold", {rdata, rresp, rlast}, held);
            stall = rvalid && !rready;
            held  = {rdata, rresp, rlast};
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL b_unexpected: got bid 0x%0h bresp %0d, want no response", bid, bresp);
                end else begin
                    be = bq.pop_front();
                    chk("bid", bid, be.id);
                    chk("bresp", bresp, be.resp);
                end
            end
            if (rvalid && rready) begin
                r_seen++;
                if (rq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL r_unexpected: got rdata 0x%0h, want no beat", rdata);
                end else begin
                    re = rq.pop_front();
                    chk("rid", rid, re.id);
                    chk("rdata", rdata, re.data);
                    chk("rresp", rresp, re.resp);
                    chk("rlast", rlast, re.last);
                end
            end
        end
    end

    // lastmode: 0 = correct wlast, 1 = wlast always high, 2 = wlast always low.
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input logic [3:0] strb, input int unsigned lastmode,
                             input logic [3:0] wid_x, input logic [1:0] exp_resp,
                             input int unsigned abort_at);
        int unsigned t;
        if (abort_at == 0) bq.push_back('{id: id, resp: exp_resp});
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!awready && t < 50) begin @(negedge clk); t++; end
        if (!awready) begin
            chk("aw_timeout", awready, 64'd1);
            awvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int unsigned b = 0; b <= len; b++) begin
            wid    = id ^ wid_x;
            wdata  = wbuf[b];
            wstrb  = strb;
            wlast  = (lastmode == 0) ? (b == len) : (lastmode == 1);
            wvalid = 1'b1;
            if (abort_at != 0 && b == abort_at) return;
            t = 0;
            @(negedge clk);
            if (b == 0) chk("wready_after_aw", wready, 64'd1);
            while (!wready && t < 50) begin @(negedge clk); t++; end
            if (!wready) begin
                chk("w_timeout", wready, 64'd1);
                wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        @(negedge clk);
        chk("bvalid_after_w", bvalid, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic toggle,
                            input logic [1:0] exp_resp);
        int unsigned t;
        int          target;
        for (int unsigned b = 0; b <= len; b++)
            rq.push_back('{id: id, data: rbuf[b], resp: exp_resp, last: (b == len)});
        target = r_seen + int'(len) + 1;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 50) begin @(negedge clk); t++; end
        if (!arready) begin
            chk("ar_timeout", arready, 64'd1);
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        t = 0;
        while (r_seen < target && t < 100) begin
            rready = toggle ? (t % 2 == 0) : 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            t++;
        end
        rready = 1'b1;
        chk("r_beats", r_seen, target);
        @(negedge clk);
        chk("arready_after_rlast", arready, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin : stim
        int unsigned t;
        resetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b1;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        resetn = 1'b1;
        @(negedge clk);
        chk("awready_post_reset", awready, 64'd1);
        chk("arready_post_reset", arready, 64'd1);
        @(posedge clk); #1;

        // INCR write/read, read with rready 1010
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        axi_write(4'h1, 32'h100, 4'd3, 2'b01, 4'hF, 0, 4'h0, 2'd0, 0);
        rbuf[0] = 32'h11; rbuf[1] = 32'h22; rbuf[2] = 32'h33; rbuf[3] = 32'h44;
        axi_read(4'h2, 32'h100, 4'd3, 3'd2, 2'b01, 1'b1, 2'd0);

        // WRAP: 0x10C, 0x100, 0x104, 0x108
        rbuf[0] = 32'h44; rbuf[1] = 32'h11; rbuf[2] = 32'h22; rbuf[3] = 32'h33;
        axi_read(4'h5, 32'h10C, 4'd3, 3'd2, 2'b10, 1'b0, 2'd0);

        // Byte strobes
        wbuf[0] = 32'hFFFF_FFFF;
        axi_write(4'h3, 32'h200, 4'd0, 2'b01, 4'hF, 0, 4'h0, 2'd0, 0);
        wbuf[0] = 32'h0000_0000;
        axi_write(4'h3, 32'h200, 4'd0, 2'b01, 4'b0101, 0, 4'h0, 2'd0, 0);
        rbuf[0] = 32'hFF00_FF00;
        axi_read(4'h4, 32'h200, 4'd0, 3'd2, 2'b01, 1'b0, 2'd0);

        // DECERR: out-of-range write must not alias onto word 0
        wbuf[0] = 32'hA5A5_A5A5;
        axi_write(4'h6, 32'h0, 4'd0, 2'b01, 4'hF, 0, 4'h0, 2'd0, 0);
        wbuf[0] = 32'hDEAD_BEEF;
        axi_write(4'h6, 32'h1000, 4'd0, 2'b01, 4'hF, 0, 4'h0, 2'd3, 0);
        rbuf[0] = 32'hA5A5_A5A5;
        axi_read(4'h6, 32'h0, 4'd0, 3'd2, 2'b01, 1'b0, 2'd0);
        rbuf[0] = 32'h0; rbuf[1] = 32'h0;
        axi_read(4'h7, 32'h1000, 4'd1, 3'd2, 2'b01, 1'b0, 2'd3);

        // SLVERR: early wlast, missing wlast, wid mismatch, oversize read
        wbuf[0] = 32'h1; wbuf[1] = 32'h2;
        axi_write(4'h8, 32'h300, 4'd1, 2'b01, 4'hF, 1, 4'h0, 2'd2, 0);
        axi_write(4'h8, 32'h300, 4'd1, 2'b01, 4'hF, 2, 4'h0, 2'd2, 0);
        axi_write(4'h9, 32'h304, 4'd0, 2'b01, 4'hF, 0, 4'h3, 2'd2, 0);
        rbuf[0] = 32'h0;
        axi_read(4'hA, 32'h100, 4'd0, 3'd3, 2'b01, 1'b0, 2'd2);

        // Reserved burst type: write discarded
        wbuf[0] = 32'h77;
        axi_write(4'hB, 32'h700, 4'd0, 2'b01, 4'hF, 0, 4'h0, 2'd0, 0);
        wbuf[0] = 32'hEE;
        axi_write(4'hB, 32'h700, 4'd0, 2'b11, 4'hF, 0, 4'h0, 2'd2, 0);
        rbuf[0] = 32'h77;
        axi_read(4'hB, 32'h700, 4'd0, 3'd2, 2'b01, 1'b0, 2'd0);

        // WRAP with len=2 is illegal
        rbuf[0] = 32'h0; rbuf[1] = 32'h0; rbuf[2] = 32'h0;
        axi_read(4'hC, 32'h100, 4'd2, 3'd2, 2'b10, 1'b0, 2'd2);

        // FIXED: both beats land on one word
        wbuf[0] = 32'hAAAA; wbuf[1] = 32'hBBBB;
        axi_write(4'hD, 32'h400, 4'd1, 2'b00, 4'hF, 0, 4'h0, 2'd0, 0);
        rbuf[0] = 32'hBBBB; rbuf[1] = 32'hBBBB;
        axi_read(4'hD, 32'h400, 4'd1, 3'd2, 2'b00, 1'b0, 2'd0);

        // Reset during beat 2 of a 4-beat write
        wbuf[0] = 32'hB0; wbuf[1] = 32'hB1; wbuf[2] = 32'hB2; wbuf[3] = 32'hB3;
        axi_write(4'hE, 32'h500, 4'd3, 2'b01, 4'hF, 0, 4'h0, 2'd0, 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        wvalid = 1'b0;
        wlast  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("awready_after_release", awready, 64'd1);
        @(posedge clk); #1;
        wbuf[0] = 32'hC0;
        axi_write(4'hF, 32'h600, 4'd0, 2'b01, 4'hF, 0, 4'h0, 2'd0, 0);
        rbuf[0] = 32'hB0;
        axi_read(4'h1, 32'h500, 4'd0, 3'd2, 2'b01, 1'b0, 2'd0);
        rbuf[0] = 32'hC0;
        axi_read(4'h2, 32'h600, 4'd0, 3'd2, 2'b01, 1'b0, 2'd0);

        t = 0;
        while ((bq.size() != 0 || rq.size() != 0) && t < 20) begin @(negedge clk); t++; end
        chk("b_pending", 64'(bq.size()), 64'd0);
        chk("r_pending", 64'(rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

Parametrised AXI3/AXI4 burst-capable memory slave that answers on all five AXI channels and serves as the standard RTL target behind the VIP master agent. It generalises the fixed 4-bit-ID/32-bit/AXI3 bus to configurable ID, address, data and burst-length widths, and adds FIXED/INCR/WRAP burst addressing, byte strobes, and OKAY/SLVERR/DECERR responses. Write and read paths are independent FSMs sharing one word-addressed storage array.

## Interface
- ID_W, 4, width of awid/wid/bid/arid/rid
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; power of 2, 8..128; STRB_W = DATA_W/8
- LEN_W, 4, burst length field width (4 = AXI3, 8 = AXI4)
- MEM_WORDS, 1024, storage depth in DATA_W words; base address 0
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/ADDR_W/LEN_W/3/2/1  write address; awready  out  1
- wid/wdata/wstrb/wlast/wvalid  in  ID_W/DATA_W/STRB_W/1/1  write data; wready  out  1
- bid/bresp/bvalid  out  ID_W/2/1  write response; bready  in  1
- arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/ADDR_W/LEN_W/3/2/1  read address; arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data; rready  in  1

## Operation
- All outputs registered. Reset values: every output 0 (awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid, rdata). Memory contents not reset.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. W_IDLE: awready=1; AW handshake latches id/addr/len/size/burst, clears beat count and error flag. W_DATA: wready=1; each beat writes the bytes enabled by wstrb at the current word, then advances the address. W_RESP: bvalid=1, bid=latched id; B handshake returns to W_IDLE.
- Burst ends after exactly len+1 beats regardless of wlast. wlast low on the final beat, or high earlier -> bresp SLVERR. In AXI3 mode (LEN_W=4), wid != awid on any beat -> SLVERR.
- Read FSM R_IDLE -> R_DATA -> R_IDLE. R_IDLE: arready=1. R_DATA: rvalid=1, rid=latched id, rlast=1 on beat len. rdata/rresp/rlast held stable while rvalid && !rready.
- Address update: FIXED holds; INCR adds 1<<size; WRAP adds 1<<size and wraps inside the (len+1)<<size aligned window. Width arithmetic in ADDR_W, wrap-around at 2^ADDR_W.
- Errors, priority DECERR > SLVERR:
  - SLVERR: size > log2(STRB_W); WRAP with len not in {1,3,7,15}; burst=2'b11. Error writes are discarded; error reads return rdata=0.
  - DECERR: any beat address >= MEM_WORDS*STRB_W. That beat's write is discarded / rdata=0. Response is sticky for B and per-beat for R.
- Simultaneous write and read of the same word in one cycle: the read returns the pre-write value.

## Timing
- Write, 1 beat: AW handshake at edge N; wready=1 from N; W accepted at N+1; bvalid=1 from N+1; with bready=1, B completes at N+2 and awready=1 from N+2. Back-to-back W beats sustain 1 beat/cycle.
- Read: AR handshake at N; first beat valid from N (rvalid, rdata registered at N); each R handshake loads the next beat by the following edge, giving 1 beat/cycle with rready held high. arready reasserts the cycle after the rlast handshake.
- No AW/W or AR acceptance while the respective FSM is busy (single outstanding transaction per direction).
- resetn asserted mid-burst: both FSMs return to IDLE immediately; outputs go to their reset values asynchronously; partially written data is kept.

## Structure
- axi_mem_pkg: burst_e (FIXED/INCR/WRAP), resp_e (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), wr_state_e, rd_state_e.
- Sub-module axi_burst_addr (instantiated twice): cur addr/size/len/burst in, next addr and illegal-burst flag out; combinational.

## Test plan
- INCR write awaddr=0x100, len=3, size=2, data 0x11..0x44 -> bresp OKAY; INCR read of the same range with rready toggled 1010 -> rdata 0x11,0x22,0x33,0x44, rlast on beat 4 only, data stable while stalled.
- WRAP read araddr=0x10C, len=3, size=2 -> beat addresses 0x10C, 0x100, 0x104, 0x108.
- Word 0x200 = 0xFFFFFFFF; write 0x00000000 with wstrb=4'b0101 -> readback 0xFF00FF00.
- Write to 0x1000 (MEM_WORDS=1024, 32-bit) -> bresp DECERR, memory unchanged; 2-beat read -> both beats rresp DECERR, rdata 0.
- Write len=1 with wlast high on beat 1 -> 2 beats accepted, bresp SLVERR; read with arsize=3 on 32-bit bus -> SLVERR.
- resetn pulsed during beat 2 of a 4-beat write -> all outputs 0; awready=1 the cycle after release; a new write completes OKAY.
